// File: rtl/pipe_ctrl_hazard.sv
// Decode-stage control unit for a 5-stage MIPS pipeline.
// Decodes opcode/funct into the ID/EX control bundle, tracks recent writers,
// inserts a one-cycle bubble on load-use hazards, selects the JR forwarding
// source by pipeline age and counts stall cycles.
// Handshake: there is no ready/valid pair here; stall=1 tells the front end to
// hold PC and IF/ID, so the same instruction is presented again next cycle,
// while ID/EX receives a bubble (ex_valid=0, all controls 0).
module pipe_ctrl_hazard #(
  parameter int FWD_DEPTH = 2,
  parameter int ALUOP_W   = 4,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [4:0]         rs,
  input  logic [4:0]         rt,
  input  logic [4:0]         rd,
  input  logic               flush,
  output logic               stall,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [1:0]         ex_jump,
  output logic [2:0]         ex_jr_fwd_sel,
  output logic [4:0]         ex_dest,
  output logic               ex_illegal,
  output logic [CNT_W-1:0]   stall_count
);

  // Decoded bundle for the instruction currently in ID
  logic               d_reg_write, d_mem_to_reg, d_mem_read, d_mem_write;
  logic               d_branch, d_reg_dst, d_alu_src, d_illegal;
  logic               d_use_rs, d_use_rt;
  logic [ALUOP_W-1:0] d_alu_op;
  logic [1:0]         d_jump;
  logic [4:0]         d_dest;
  logic [2:0]         jr_sel;
  logic               issue;

  // Writer history: index 1 is the instruction now in EX, index k is k stages older
  logic       h_valid [1:FWD_DEPTH];
  logic [4:0] h_addr  [1:FWD_DEPTH];
  logic       h_load  [1:FWD_DEPTH];

  // Combinational decode of opcode/funct; every bit defaults to 0
  always_comb begin
    d_reg_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_branch     = 1'b0;
    d_reg_dst    = 1'b0;
    d_alu_src    = 1'b0;
    d_illegal    = 1'b0;
    d_use_rs     = 1'b0;
    d_use_rt     = 1'b0;
    d_alu_op     = '0;
    d_jump       = 2'b00;
    d_dest       = 5'd0;
    case (opcode)
      6'h00: begin
        // R-type: ALU ops write rd and read rs/rt; shifts do not read rs
        d_reg_write = 1'b1;
        d_dest      = rd;
        d_use_rs    = 1'b1;
        d_use_rt    = 1'b1;
        case (funct)
          6'h20: d_alu_op = ALUOP_W'(4'h1);
          6'h21: d_alu_op = ALUOP_W'(4'hA);
          6'h22: d_alu_op = ALUOP_W'(4'h2);
          6'h23: d_alu_op = ALUOP_W'(4'hB);
          6'h24: d_alu_op = ALUOP_W'(4'h3);
          6'h25: d_alu_op = ALUOP_W'(4'h4);
          6'h27: d_alu_op = ALUOP_W'(4'h5);
          6'h2A: d_alu_op = ALUOP_W'(4'h6);
          6'h00: begin d_alu_op = ALUOP_W'(4'h7); d_use_rs = 1'b0; end
          6'h02: begin d_alu_op = ALUOP_W'(4'h8); d_use_rs = 1'b0; end
          6'h03: begin d_alu_op = ALUOP_W'(4'h9); d_use_rs = 1'b0; end
          6'h08: begin
            // JR reads only rs and writes nothing
            d_jump      = 2'b10;
            d_reg_write = 1'b0;
            d_dest      = 5'd0;
            d_use_rt    = 1'b0;
          end
          default: begin
            d_illegal   = 1'b1;
            d_reg_write = 1'b0;
            d_dest      = 5'd0;
            d_use_rs    = 1'b0;
            d_use_rt    = 1'b0;
          end
        endcase
      end
      6'h0C, 6'h08, 6'h0D, 6'h0A, 6'h09, 6'h0F: begin
        // I-type ALU: immediate operand, writes rt; lui has no register source
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_reg_dst   = 1'b1;
        d_dest      = rt;
        d_use_rs    = (opcode != 6'h0F);
        case (opcode)
          6'h0C:   d_alu_op = ALUOP_W'(4'h3);
          6'h08:   d_alu_op = ALUOP_W'(4'h1);
          6'h0D:   d_alu_op = ALUOP_W'(4'h4);
          6'h0A:   d_alu_op = ALUOP_W'(4'h6);
          6'h09:   d_alu_op = ALUOP_W'(4'hA);
          default: d_alu_op = ALUOP_W'(4'hF);
        endcase
      end
      6'h04: begin d_branch = 1'b1; d_alu_op = ALUOP_W'(4'h2); d_use_rs = 1'b1; d_use_rt = 1'b1; end
      6'h05: begin d_branch = 1'b1; d_alu_op = ALUOP_W'(4'hE); d_use_rs = 1'b1; d_use_rt = 1'b1; end
      6'h07: begin d_branch = 1'b1; d_alu_op = ALUOP_W'(4'hC); d_use_rs = 1'b1; end
      6'h01: begin d_branch = 1'b1; d_alu_op = ALUOP_W'(4'hD); d_use_rs = 1'b1; end
      6'h23: begin
        d_alu_op     = ALUOP_W'(4'h1);
        d_alu_src    = 1'b1;
        d_reg_write  = 1'b1;
        d_reg_dst    = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_dest       = rt;
        d_use_rs     = 1'b1;
      end
      6'h2B: begin
        d_alu_op    = ALUOP_W'(4'h1);
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
        d_use_rs    = 1'b1;
        d_use_rt    = 1'b1;
      end
      6'h02: d_jump = 2'b01;
      6'h03: begin d_jump = 2'b11; d_reg_write = 1'b1; d_dest = 5'd31; end
      default: d_illegal = 1'b1;
    endcase
  end

  // Load-use hazard against the load now in EX; flush and reset suppress it
  always_comb begin
    stall = rst_n && id_valid && !flush && h_valid[1] && h_load[1] &&
            ((d_use_rs && (h_addr[1] == rs)) || (d_use_rt && (h_addr[1] == rt)));
    issue = id_valid && !flush && !stall;
  end

  // JR forwarding source: youngest valid history entry writing rs
  always_comb begin
    jr_sel = 3'd0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (h_valid[k] && (h_addr[k] == rs)) jr_sel = 3'(k);
    end
    if (d_jump != 2'b10) jr_sel = 3'd0;
  end

  // ID/EX register, writer history shift and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      ex_jump       <= 2'b00;
      ex_jr_fwd_sel <= 3'd0;
      ex_dest       <= 5'd0;
      ex_illegal    <= 1'b0;
      stall_count   <= '0;
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        h_valid[k] <= 1'b0;
        h_addr[k]  <= 5'd0;
        h_load[k]  <= 1'b0;
      end
    end else begin
      ex_valid      <= issue;
      ex_reg_write  <= issue && d_reg_write;
      ex_mem_to_reg <= issue && d_mem_to_reg;
      ex_mem_read   <= issue && d_mem_read;
      ex_mem_write  <= issue && d_mem_write;
      ex_branch     <= issue && d_branch;
      ex_reg_dst    <= issue && d_reg_dst;
      ex_alu_src    <= issue && d_alu_src;
      ex_alu_op     <= issue ? d_alu_op : '0;
      ex_jump       <= issue ? d_jump : 2'b00;
      ex_jr_fwd_sel <= issue ? jr_sel : 3'd0;
      ex_dest       <= issue ? d_dest : 5'd0;
      ex_illegal    <= issue && d_illegal;
      // Writes to $0 are never tracked, so they can neither stall nor forward
      h_valid[1] <= issue && d_reg_write && (d_dest != 5'd0);
      h_addr[1]  <= d_dest;
      h_load[1]  <= issue && d_mem_read;
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        h_valid[k] <= h_valid[k-1];
        h_addr[k]  <= h_addr[k-1];
        h_load[k]  <= h_load[k-1];
      end
      if (stall && (stall_count != {CNT_W{1'b1}})) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: doc/pipe_ctrl_hazard.md
Name: pipe_ctrl_hazard

Overview:
- Next-generation decode-stage control unit for the 5-stage MIPS pipeline.
- Decodes opcode/funct into the control bundle and registers it into the ID/EX stage.
- Tracks the destinations of the last FWD_DEPTH in-flight writers, detects load-use hazards and generates stall/bubble.
- Selects JR forwarding source by pipeline age, honours branch flush, and counts stall cycles.

Parameters:
- FWD_DEPTH, 2, number of tracked older writer stages (legal range 1..4); entry 1 is youngest (EX), entry k is k stages older.
- ALUOP_W, 4, ALU operation code width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- rs  in  5  instr[25:21].
- rt  in  5  instr[20:16].
- rd  in  5  instr[15:11].
- flush  in  1  taken branch/jump resolved downstream; kill the decode-stage instruction.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  registered; ID/EX holds a real instruction.
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_reg_dst, ex_alu_src  out  1 each  registered control bits.
- ex_alu_op  out  ALUOP_W  registered ALU code.
- ex_jump  out  2  registered: 00 none, 01 j, 10 jr, 11 jal.
- ex_jr_fwd_sel  out  3  registered: 0 = register file, k = forward from history entry k.
- ex_dest  out  5  registered write-back register number.
- ex_illegal  out  1  registered; undefined opcode/funct decoded.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Decode (combinational; all bits default 0).
  - R-type (op 00), all with RegWrite=1, dest=rd, and ALUOp by funct: 20→1, 21→A, 22→2, 23→B, 24→3, 25→4, 27→5, 2A→6, 00→7, 02→8, 03→9.
  - R-type funct 08 is JR: jump=10, no write.
  - I-type ALU ops, all with ALUSrc=1, RegWrite=1, RegDst=1, dest=rt: 0C→3, 08→1, 0D→4, 0A→6, 09→A, 0F→F.
  - Branches, all with Branch=1: 04→2, 05→E, 07→C, 01→D.
  - lw 23: ALUOp 1, ALUSrc, RegWrite, RegDst, MemRead, MemToReg, dest=rt.
  - sw 2B: ALUOp 1, ALUSrc, MemWrite.
  - j 02: jump=01.
  - jal 03: jump=11, RegWrite=1, dest=31.
  - Any other code: illegal=1 with all other controls 0.
- rt is a source operand for R-type, beq, bne and sw; rs is a source for everything except j, jal, lui and shifts.
- History:
  - Shift register of FWD_DEPTH entries {valid, addr, is_load}; shifts every cycle.
  - Entry 1 is loaded from the instruction entering ID/EX.
  - It is pushed valid only if the entering instruction has RegWrite=1 and dest≠0; otherwise it is pushed invalid.
- Load-use stall:
  - stall=1 when id_valid, flush=0, entry1.valid, entry1.is_load, and entry1.addr equals a source register in use (rs or rt; rs for JR).
  - On stall, ID/EX loads a bubble: ex_valid=0 and all controls 0.
  - Inputs are held externally, so the instruction re-decodes next cycle; stall lasts exactly 1 cycle.
- JR forwarding: ex_jr_fwd_sel = smallest k with entry k valid and addr==rs, else 0. The youngest match wins.
- Flush:
  - flush=1 forces a bubble into ID/EX and forces stall=0; flush has priority over stall.
  - History still shifts.
- id_valid=0 loads a bubble; a bubble never sets ex_illegal.
- Reset (rst_n=0 at an edge): all ex_* outputs 0, all history entries invalid, stall_count=0. stall is 0 while rst_n=0.
  - Reset mid-stall discards the pending hazard.
- stall_count increments on each stall cycle and saturates at all-ones.
- Latency: decode to ex_* is 1 cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with lw decoding → all ex_* 0, stall=0, stall_count=0.
- Decode sweep: addu $3,$1,$2 → ex_alu_op=A, ex_reg_write=1, ex_reg_dst=0, ex_dest=3. lui $5 → alu_op=F, alu_src=1, ex_dest=5. op 3F → ex_illegal=1, other controls 0.
- Load-use: lw $8 followed by add $9,$8,$4 → stall=1 for exactly one cycle, a bubble in ID/EX, then add issues; stall_count=1.
- JR forwarding (FWD_DEPTH=2): addi $31 then jr $31 → ex_jr_fwd_sel=1. With a nop in between → 2. With two nops → 0. With jal then jr $31 → 1.
- Flush priority: flush=1 on the same cycle as a load-use hazard → stall=0, bubble, stall_count unchanged.
- Write to $0: addi $0 followed by add using $0 as a source → no stall, JR sel 0; stall_count held at all-ones with CNT_W=2 after 5 stalls.
